// File: rtl/keypad_code_lock_if.sv
// keypad_code_lock_if: decoded key events into the lock and lock status back out.
interface keypad_code_lock_if #(
   parameter int CODE_LEN  = 4,
   parameter int DIGIT_W   = 4,
   parameter int MAX_TRIES = 3
);
   logic                             key_valid;
   logic [DIGIT_W-1:0]               key_code;
   logic                             unlocked;
   logic                             wrong_pulse;
   logic                             code_updated;
   logic                             locked_out;
   logic [$clog2(CODE_LEN+1)-1:0]    digit_count;
   logic [$clog2(MAX_TRIES+1)-1:0]   tries_used;
   modport master (output key_valid, key_code,
                   input unlocked, wrong_pulse, code_updated, locked_out, digit_count, tries_used);
   modport slave (input key_valid, key_code,
                  output unlocked, wrong_pulse, code_updated, locked_out, digit_count, tries_used);
endinterface

// File: rtl/keypad_code_lock.sv
// keypad_code_lock: code entry, verification, reprogramming and lockout controller.
// Define KEYPAD_LOCK_LOCKOUT_EN to build the LOCKOUT state and its timer.
module keypad_code_lock #(
   parameter int                          CODE_LEN       = 4,
   parameter int                          DIGIT_W        = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 16'h1234,
   parameter int                          MAX_TRIES      = 3,
   parameter int                          UNLOCK_CYCLES  = 60_000_000,
   parameter int                          LOCKOUT_CYCLES = 120_000_000
) (
   input logic               hwclk,
   input logic               reset,
   keypad_code_lock_if.slave kp
);
   localparam int CW = CODE_LEN * DIGIT_W;
   localparam int NW = $clog2(CODE_LEN + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int UW = $clog2(UNLOCK_CYCLES + 1);
`ifdef KEYPAD_LOCK_LOCKOUT_EN
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
`endif
   if (CODE_LEN < 1 || CODE_LEN > 16 || MAX_TRIES < 1 || UNLOCK_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
      $error("keypad_code_lock: parameter out of range");
   end
   typedef enum logic [2:0] {
      IDLE, COMPARE, UNLOCKED, PROGRAM_CMP
`ifdef KEYPAD_LOCK_LOCKOUT_EN
      , LOCKOUT
`endif
   } state_t;
   state_t         state, state_n;
   logic [CW-1:0]  entry, entry_n, stored, stored_n;
   logic [NW-1:0]  cnt, cnt_n;
   logic [TW-1:0]  tries, tries_n;
   logic [UW-1:0]  ut, ut_n;
   logic           ovf, ovf_n, wrong_n, upd_n;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
   logic [LW-1:0]  lt, lt_n;
`endif
   logic acc, dig, clr, ent, full, match;
   assign acc   = state == IDLE || state == UNLOCKED;
   assign dig   = kp.key_valid && kp.key_code < DIGIT_W'(10);
   assign clr   = kp.key_valid && kp.key_code == DIGIT_W'(10);
   assign ent   = kp.key_valid && kp.key_code == DIGIT_W'(11);
   assign full  = cnt == NW'(CODE_LEN);
   assign match = full && !ovf && entry == stored;
   assign kp.digit_count = cnt;
   assign kp.tries_used  = tries;
   always_comb begin
      state_n  = state;
      entry_n  = entry;
      stored_n = stored;
      cnt_n    = cnt;
      ovf_n    = ovf;
      tries_n  = tries;
      ut_n     = ut;
      wrong_n  = 1'b0;
      upd_n    = 1'b0;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
      lt_n     = lt;
`endif
      if (acc && dig) begin
         ovf_n   = full ? 1'b1 : ovf;
         entry_n = full ? entry : (entry << DIGIT_W) | CW'(kp.key_code);
         cnt_n   = full ? cnt : cnt + 1'b1;
      end
      if (acc && clr) begin
         entry_n = '0;
         cnt_n   = '0;
         ovf_n   = 1'b0;
      end
      case (state)
         IDLE: state_n = ent ? COMPARE : IDLE;
         COMPARE: begin
            entry_n = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            if (match) begin
               state_n = UNLOCKED;
               tries_n = '0;
               ut_n    = UW'(UNLOCK_CYCLES);
            end else begin
               wrong_n = 1'b1;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
               tries_n = tries + 1'b1;
               if (tries_n == TW'(MAX_TRIES)) begin
                  state_n = LOCKOUT;
                  lt_n    = LW'(LOCKOUT_CYCLES);
               end else state_n = IDLE;
`else
               tries_n = (tries == TW'(MAX_TRIES)) ? tries : tries + 1'b1;
               state_n = IDLE;
`endif
            end
         end
         UNLOCKED: begin
            ut_n = ut - 1'b1;
            if (ut == UW'(1)) begin
               state_n = IDLE;
               entry_n = '0;
               cnt_n   = '0;
               ovf_n   = 1'b0;
            end else if (clr && cnt == '0) state_n = IDLE;
            else if (ent) state_n = PROGRAM_CMP;
         end
         PROGRAM_CMP: begin
            entry_n = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            if (full && !ovf) begin
               stored_n = entry;
               upd_n    = 1'b1;
               state_n  = IDLE;
            end else begin
               wrong_n = 1'b1;
               state_n = UNLOCKED;
               ut_n    = UW'(UNLOCK_CYCLES);
            end
         end
`ifdef KEYPAD_LOCK_LOCKOUT_EN
         LOCKOUT: begin
            lt_n = lt - 1'b1;
            if (lt == LW'(1)) begin
               state_n = IDLE;
               tries_n = '0;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge hwclk) begin
      if (reset) begin
         state           <= IDLE;
         entry           <= '0;
         stored          <= DEFAULT_CODE;
         cnt             <= '0;
         ovf             <= 1'b0;
         tries           <= '0;
         ut              <= '0;
         kp.unlocked     <= 1'b0;
         kp.wrong_pulse  <= 1'b0;
         kp.code_updated <= 1'b0;
      end else begin
         state           <= state_n;
         entry           <= entry_n;
         stored          <= stored_n;
         cnt             <= cnt_n;
         ovf             <= ovf_n;
         tries           <= tries_n;
         ut              <= ut_n;
         kp.unlocked     <= state_n == UNLOCKED || state_n == PROGRAM_CMP;
         kp.wrong_pulse  <= wrong_n;
         kp.code_updated <= upd_n;
      end
   end
`ifdef KEYPAD_LOCK_LOCKOUT_EN
   always_ff @(posedge hwclk) begin
      if (reset) begin
         lt            <= '0;
         kp.locked_out <= 1'b0;
      end else begin
         lt            <= lt_n;
         kp.locked_out <= state_n == LOCKOUT;
      end
   end
`else
   assign kp.locked_out = 1'b0;
`endif
endmodule

// File: tb/tb_keypad_code_lock.sv
// tb_keypad_code_lock: directed tests for keypad_code_lock with hand-computed expectations.
module tb_keypad_code_lock;
   logic hwclk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 hwclk = ~hwclk;
   keypad_code_lock_if #(.CODE_LEN(4), .DIGIT_W(4), .MAX_TRIES(3)) kp ();
   keypad_code_lock #(
      .CODE_LEN(4), .DIGIT_W(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(3),
      .UNLOCK_CYCLES(50), .LOCKOUT_CYCLES(20)
   ) dut (.hwclk(hwclk), .reset(reset), .kp(kp));
   task automatic step();
      @(posedge hwclk);
      #1;
   endtask
   // One key per cycle, so consecutive calls give back-to-back pulses.
   task automatic press(input logic [3:0] k);
      kp.key_valid = 1'b1;
      kp.key_code  = k;
      step();
      kp.key_valid = 1'b0;
      kp.key_code  = 4'h0;
   endtask
   task automatic send_code(input logic [31:0] keys, input int n);
      for (int i = n - 1; i >= 0; i--) press(keys[i*4 +: 4]);
   endtask
   task automatic test_reset();
      kp.key_valid = 1'b0;
      kp.key_code  = 4'h0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked: got %0b want 0", kp.unlocked); end
      n_chk++; if (kp.wrong_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrong: got %0b want 0", kp.wrong_pulse); end
      n_chk++; if (kp.code_updated !== 1'b0) begin n_fail++; $display("FAIL reset_updated: got %0b want 0", kp.code_updated); end
      n_chk++; if (kp.locked_out !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", kp.locked_out); end
      n_chk++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", kp.digit_count); end
      n_chk++; if (kp.tries_used !== 2'd0) begin n_fail++; $display("FAIL reset_tries: got %0d want 0", kp.tries_used); end
   endtask
   task automatic test_unlock();
      press(4'h1);
      n_chk++; if (kp.digit_count !== 3'd1) begin n_fail++; $display("FAIL count_one: got %0d want 1", kp.digit_count); end
      press(4'h2);
      press(4'hC);
      n_chk++; if (kp.digit_count !== 3'd2) begin n_fail++; $display("FAIL ignored_key: got %0d want 2", kp.digit_count); end
      send_code(32'h34B, 3);
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL unlock_early: got %0b want 0", kp.unlocked); end
      step();
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL unlock_rise: got %0b want 1", kp.unlocked); end
      n_chk++; if (kp.tries_used !== 2'd0) begin n_fail++; $display("FAIL unlock_tries: got %0d want 0", kp.tries_used); end
      n_chk++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL unlock_count: got %0d want 0", kp.digit_count); end
      repeat (49) step();
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL unlock_hold50: got %0b want 1", kp.unlocked); end
      step();
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL unlock_expire: got %0b want 0", kp.unlocked); end
   endtask
   task automatic test_wrong();
      send_code(32'h1235B, 5);
      n_chk++; if (kp.wrong_pulse !== 1'b0) begin n_fail++; $display("FAIL wrong_early: got %0b want 0", kp.wrong_pulse); end
      step();
      n_chk++; if (kp.wrong_pulse !== 1'b1) begin n_fail++; $display("FAIL wrong_pulse: got %0b want 1", kp.wrong_pulse); end
      n_chk++; if (kp.tries_used !== 2'd1) begin n_fail++; $display("FAIL wrong_tries1: got %0d want 1", kp.tries_used); end
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL wrong_unlocked: got %0b want 0", kp.unlocked); end
      step();
      n_chk++; if (kp.wrong_pulse !== 1'b0) begin n_fail++; $display("FAIL wrong_width: got %0b want 0", kp.wrong_pulse); end
      send_code(32'h12345, 5);
      n_chk++; if (kp.digit_count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d want 4", kp.digit_count); end
      press(4'hB);
      step();
      n_chk++; if (kp.wrong_pulse !== 1'b1) begin n_fail++; $display("FAIL overflow_wrong: got %0b want 1", kp.wrong_pulse); end
      n_chk++; if (kp.tries_used !== 2'd2) begin n_fail++; $display("FAIL overflow_tries: got %0d want 2", kp.tries_used); end
   endtask
`ifdef KEYPAD_LOCK_LOCKOUT_EN
   task automatic test_lockout();
      send_code(32'h1235B, 5);
      step();
      n_chk++; if (kp.wrong_pulse !== 1'b1) begin n_fail++; $display("FAIL lock_wrong: got %0b want 1", kp.wrong_pulse); end
      n_chk++; if (kp.locked_out !== 1'b1) begin n_fail++; $display("FAIL lock_rise: got %0b want 1", kp.locked_out); end
      n_chk++; if (kp.tries_used !== 2'd3) begin n_fail++; $display("FAIL lock_tries: got %0d want 3", kp.tries_used); end
      send_code(32'h1234B, 5);
      step();
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL lock_ignore: got %0b want 0", kp.unlocked); end
      n_chk++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL lock_count: got %0d want 0", kp.digit_count); end
      repeat (13) step();
      n_chk++; if (kp.locked_out !== 1'b1) begin n_fail++; $display("FAIL lock_hold20: got %0b want 1", kp.locked_out); end
      step();
      n_chk++; if (kp.locked_out !== 1'b0) begin n_fail++; $display("FAIL lock_expire: got %0b want 0", kp.locked_out); end
      n_chk++; if (kp.tries_used !== 2'd0) begin n_fail++; $display("FAIL lock_tries_clr: got %0d want 0", kp.tries_used); end
      send_code(32'h1234B, 5);
      step();
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL lock_after_unlock: got %0b want 1", kp.unlocked); end
   endtask
`else
   task automatic test_saturate();
      for (int i = 0; i < 3; i++) begin
         send_code(32'h1235B, 5);
         step();
         n_chk++; if (kp.wrong_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_wrong%0d: got %0b want 1", i, kp.wrong_pulse); end
         n_chk++; if (kp.locked_out !== 1'b0) begin n_fail++; $display("FAIL sat_locked%0d: got %0b want 0", i, kp.locked_out); end
      end
      n_chk++; if (kp.tries_used !== 2'd3) begin n_fail++; $display("FAIL sat_tries: got %0d want 3", kp.tries_used); end
      send_code(32'h1234B, 5);
      step();
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL sat_unlock: got %0b want 1", kp.unlocked); end
      n_chk++; if (kp.tries_used !== 2'd0) begin n_fail++; $display("FAIL sat_tries_clr: got %0d want 0", kp.tries_used); end
   endtask
`endif
   task automatic test_program();
      send_code(32'h9876B, 5);
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_open: got %0b want 1", kp.unlocked); end
      step();
      n_chk++; if (kp.code_updated !== 1'b1) begin n_fail++; $display("FAIL prog_updated: got %0b want 1", kp.code_updated); end
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL prog_relock: got %0b want 0", kp.unlocked); end
      step();
      n_chk++; if (kp.code_updated !== 1'b0) begin n_fail++; $display("FAIL prog_width: got %0b want 0", kp.code_updated); end
      send_code(32'h1234B, 5);
      step();
      n_chk++; if (kp.wrong_pulse !== 1'b1) begin n_fail++; $display("FAIL prog_old_code: got %0b want 1", kp.wrong_pulse); end
      send_code(32'h9876B, 5);
      step();
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_new_code: got %0b want 1", kp.unlocked); end
      send_code(32'h98B, 3);
      step();
      n_chk++; if (kp.wrong_pulse !== 1'b1) begin n_fail++; $display("FAIL prog_short_wrong: got %0b want 1", kp.wrong_pulse); end
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL prog_short_open: got %0b want 1", kp.unlocked); end
      n_chk++; if (kp.code_updated !== 1'b0) begin n_fail++; $display("FAIL prog_short_upd: got %0b want 0", kp.code_updated); end
      n_chk++; if (kp.tries_used !== 2'd0) begin n_fail++; $display("FAIL prog_short_tries: got %0d want 0", kp.tries_used); end
   endtask
   task automatic test_reset_mid();
      send_code(32'h12, 2);
      n_chk++; if (kp.digit_count !== 3'd2) begin n_fail++; $display("FAIL mid_count: got %0d want 2", kp.digit_count); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_chk++; if (kp.digit_count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", kp.digit_count); end
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL mid_reset_open: got %0b want 0", kp.unlocked); end
      send_code(32'h34B, 3);
      step();
      n_chk++; if (kp.wrong_pulse !== 1'b1) begin n_fail++; $display("FAIL mid_wrong: got %0b want 1", kp.wrong_pulse); end
      send_code(32'h1234B, 5);
      step();
      n_chk++; if (kp.unlocked !== 1'b1) begin n_fail++; $display("FAIL mid_default_code: got %0b want 1", kp.unlocked); end
      press(4'hA);
      n_chk++; if (kp.unlocked !== 1'b0) begin n_fail++; $display("FAIL clear_relock: got %0b want 0", kp.unlocked); end
   endtask
   initial begin
      test_reset();
      test_unlock();
      test_wrong();
`ifdef KEYPAD_LOCK_LOCKOUT_EN
      test_lockout();
`else
      test_saturate();
`endif
      test_program();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/keypad_code_lock.md
# keypad_code_lock

Parametrised code-entry and verification controller for the keypad digital lock. It consumes decoded key events from the keypad scanner, accumulates a CODE_LEN-digit entry and compares it against a stored code. It drives unlock, wrong-attempt and lockout status, and allows the stored code to be reprogrammed while unlocked. It replaces the fixed-length checker and its ad-hoc valid flags in the top level with a single state machine clocked from hwclk.

## Interface
- CODE_LEN, 4: digits per code (1–16)
- DIGIT_W, 4: width of one key code
- DEFAULT_CODE, 16'h1234: reset value of the stored code, CODE_LEN*DIGIT_W bits; first digit in the MS slot
- MAX_TRIES, 3: consecutive wrong attempts before lockout (≥1)
- UNLOCK_CYCLES, 60_000_000: hwclk cycles unlocked stays asserted
- LOCKOUT_CYCLES, 120_000_000: hwclk cycles keys are ignored after MAX_TRIES failures
- hwclk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle pulse: key_code is valid this cycle
- key_code  in  DIGIT_W  0–9 digit, 10 = clear (*), 11 = enter (#), 12–15 ignored
- unlocked  out  1  lock open
- wrong_pulse  out  1  one-cycle pulse on a failed attempt
- code_updated  out  1  one-cycle pulse when a new code is stored
- locked_out  out  1  lockout active
- digit_count  out  $clog2(CODE_LEN+1)  digits currently buffered, saturating at CODE_LEN
- tries_used  out  $clog2(MAX_TRIES+1)  consecutive failures since last success or lockout

## Operation
- States: IDLE, COMPARE, UNLOCKED, PROGRAM_CMP, LOCKOUT.
- Entry buffer: a digit shifts in at the LS slot: buf <= {buf[rest], digit}, digit_count++. If a digit arrives at digit_count==CODE_LEN, the overflow flag is set, the buffer holds its contents and digit_count stays at CODE_LEN.
- Clear key: buffer, digit_count and overflow go to 0.
- IDLE + enter → COMPARE. The comparison matches iff digit_count==CODE_LEN && !overflow && buf==stored.
- COMPARE, match → UNLOCKED. tries_used is set to 0 and the unlock timer is loaded.
- COMPARE, mismatch → wrong_pulse is asserted and tries_used increments. If the new value equals MAX_TRIES → LOCKOUT, otherwise → IDLE.
- The buffer, digit_count and overflow clear on every exit from COMPARE.
- UNLOCKED: digits and clear are buffered as above. Enter → PROGRAM_CMP.
  - Clear pressed with digit_count==0 relocks immediately → IDLE.
  - Timer expiry → IDLE and the buffer clears.
- PROGRAM_CMP, digit_count==CODE_LEN && !overflow: stored <= buf, code_updated pulses, → IDLE.
- PROGRAM_CMP, any other buffer: stored code is unchanged, wrong_pulse is asserted, → UNLOCKED with the timer reloaded. tries_used does not change.
- LOCKOUT: all keys are ignored and locked_out=1. After LOCKOUT_CYCLES → IDLE with tries_used=0.
- key_valid is ignored in COMPARE and PROGRAM_CMP.
- key_code values 12–15 are ignored in every state.
- Reset values:
  - state=IDLE
  - unlocked=0, wrong_pulse=0, code_updated=0, locked_out=0
  - digit_count=0, tries_used=0
  - stored=DEFAULT_CODE, buffer and overflow cleared
- Reset applies in every state, mid-entry and mid-timer included.

## Timing
- All outputs are registered.
- Enter sampled at edge N: the state is COMPARE (or PROGRAM_CMP) during N+1. From edge N+2:
  - on a match, unlocked=1;
  - on a failure, wrong_pulse is high for exactly the N+2 cycle;
  - on a store, code_updated is high for exactly the N+2 cycle.
- digit_count updates one cycle after the key_valid edge.
- unlocked stays high for exactly UNLOCK_CYCLES cycles. A relock by clear drops it on the edge after the clear is sampled.
- locked_out rises together with the failing wrong_pulse and stays high for LOCKOUT_CYCLES cycles.
- Timers are down-counters of width $clog2(max+1). They do not wrap and reload only on state entry.
- Every key_valid pulse in an accepting state is consumed; back-to-back pulses on consecutive cycles are both taken.

## Configuration
- KEYPAD_LOCK_LOCKOUT_EN defined: LOCKOUT state, the lockout timer and locked_out behave as above.
- KEYPAD_LOCK_LOCKOUT_EN undefined:
  - LOCKOUT and its timer are not built and locked_out is tied to 0.
  - A failure never leaves the IDLE/COMPARE loop.
  - tries_used saturates at MAX_TRIES and still clears on success.

## Test plan
Bench parameters: CODE_LEN=4, UNLOCK_CYCLES=50, LOCKOUT_CYCLES=20, DEFAULT_CODE=16'h1234.
- Keys 1,2,3,4,# → unlocked=1 two cycles after #, held for 50 cycles, then 0; tries_used=0.
- Keys 1,2,3,5,# → wrong_pulse for one cycle, tries_used=1, unlocked=0. Then keys 1,2,3,4,5,# (overflow) → wrong_pulse, tries_used=2.
- Three wrong codes → locked_out=1 for 20 cycles. Keys 1,2,3,4,# sent during lockout → no response. After lockout tries_used=0, and 1,2,3,4,# unlocks.
- Unlock, then keys 9,8,7,6,# → code_updated pulse. Then 1,2,3,4,# → wrong_pulse, and 9,8,7,6,# → unlocked.
- Enter 1,2, assert reset for one cycle, then 3,4,# → wrong_pulse; digit_count was 0 after reset. Unlock, then * with an empty buffer → unlocked drops next cycle.
- With KEYPAD_LOCK_LOCKOUT_EN undefined: five wrong codes → locked_out stays 0, tries_used saturates at 3, and 1,2,3,4,# still unlocks.
